// File: rtl/ber_sync_checker_pkg.sv
// Shared constants for the PRBS bit-error-rate sync checker: state encoding,
// standard polynomial pairs and the phase-select width helper.
package ber_sync_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEED   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCK   = 2'd3
   } state_e;

   localparam int PRBS9_LEN  = 9;
   localparam int PRBS9_TAP  = 5;
   localparam int PRBS7_LEN  = 7;
   localparam int PRBS7_TAP  = 6;
   localparam int PRBS15_LEN = 15;
   localparam int PRBS15_TAP = 14;

   // A single-phase build still needs a 1-bit select port.
   function automatic int nb_phase_f(input int n_phases);
      return (n_phases > 1) ? $clog2(n_phases) : 1;
   endfunction

endpackage

// File: rtl/ber_sync_checker_if.sv
// Sample/control/status bundle of the BER sync checker; the checker sits on
// the slave side, the sample source and status consumer on the master side.
interface ber_sync_checker_if #(
   parameter int NB_INPUT   = 8,
   parameter int N_PHASES   = 4,
   parameter int NB_BER_CNT = 64
);
   localparam int NB_PHASE = ber_sync_checker_pkg::nb_phase_f(N_PHASES);

   logic                  i_en;
   logic                  i_valid;
   logic [NB_INPUT-1:0]   i_data;
   logic [NB_PHASE-1:0]   i_phase_sel;
   logic                  i_clear;

   logic                  o_lock;
   logic [1:0]            o_state;
   logic [NB_BER_CNT-1:0] o_ber_samp;
   logic [NB_BER_CNT-1:0] o_ber_error;
   logic                  o_ber_zero;
   logic [7:0]            o_resync_cnt;

   modport master (
      output i_en, i_valid, i_data, i_phase_sel, i_clear,
      input  o_lock, o_state, o_ber_samp, o_ber_error, o_ber_zero, o_resync_cnt
   );

   modport slave (
      input  i_en, i_valid, i_data, i_phase_sel, i_clear,
      output o_lock, o_state, o_ber_samp, o_ber_error, o_ber_zero, o_resync_cnt
   );

endinterface

// File: rtl/ber_sync_checker_prbs_lfsr_load.sv
// Fibonacci PRBS register x^PRBS_LEN + x^PRBS_TAP + 1 that can either free-run
// on its own feedback (generator / predictor) or shift in an external bit (seeding).
module prbs_lfsr_load #(
   parameter int PRBS_LEN = 9,
   parameter int PRBS_TAP = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                step_i,
   input  logic                load_sel_i,
   input  logic                load_bit_i,
   output logic                fb_o,
   output logic [PRBS_LEN-1:0] state_o
);

   logic [PRBS_LEN-1:0] s_q, s_d;
   logic                fb;
   logic                ins;

   assign fb  = s_q[PRBS_LEN-1] ^ s_q[PRBS_TAP-1];
   assign ins = load_sel_i ? load_bit_i : fb;

   always_comb begin
      s_d = s_q;
      if (step_i) s_d = {s_q[PRBS_LEN-2:0], ins};
   end

   // All-ones start keeps a free-running generator out of the dead state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_q <= '1;
      else        s_q <= s_d;
   end

   assign fb_o    = fb;
   assign state_o = s_q;

endmodule

// File: rtl/ber_sync_checker.sv
// PRBS sync checker: seeds a local LFSR from the selected sampling phase,
// verifies one window, then counts symbols/errors while locked.
module ber_sync_checker
   import ber_sync_checker_pkg::*;
#(
   parameter int NB_INPUT   = 8,
   parameter int N_PHASES   = 4,
   parameter int PRBS_LEN   = PRBS9_LEN,
   parameter int PRBS_TAP   = PRBS9_TAP,
   parameter int N_WINDOW   = 511,
   parameter int LOCK_THR   = 0,
   parameter int LOST_THR   = 64,
   parameter int NB_BER_CNT = 64
) (
   input logic               clk,
   input logic               i_rst_n,
   ber_sync_checker_if.slave bus_if
);

   localparam int NB_PHASE = nb_phase_f(N_PHASES);
   localparam int WIN_MAX  = (N_WINDOW > PRBS_LEN) ? N_WINDOW : PRBS_LEN;
   localparam int NB_WIN   = $clog2(WIN_MAX + 1);

   state_e                state_q, state_d;
   logic [NB_PHASE-1:0]   phase_q, phase_d;
   logic [NB_WIN-1:0]     win_cnt_q, win_cnt_d;
   logic [NB_WIN-1:0]     win_err_q, win_err_d;
   logic [NB_BER_CNT-1:0] samp_q, samp_d;
   logic [NB_BER_CNT-1:0] berr_q, berr_d;
   logic [7:0]            resync_q, resync_d;
   logic                  ber_zero_q, ber_zero_d;

   logic                  beat, strobe, slicer, fb, err_bit;
   logic                  in_check, lock_strobe, win_end, seed_end, lock_lost;
   logic [31:0]           win_err_tot;
   logic [NB_INPUT-1:0]   sample_unused;
   logic [PRBS_LEN-1:0]   lfsr_state_unused;

   // Only the slicer MSB matters; the soft bits below it are ignored.
   assign sample_unused = bus_if.i_data;
   assign slicer        = bus_if.i_data[NB_INPUT-1];

   assign beat        = bus_if.i_en && bus_if.i_valid;
   assign strobe      = beat && (phase_q == bus_if.i_phase_sel);
   assign in_check    = (state_q == ST_VERIFY) || (state_q == ST_LOCK);
   assign err_bit     = slicer ^ fb;
   assign lock_strobe = strobe && (state_q == ST_LOCK);
   assign win_end     = strobe && in_check && (win_cnt_q == NB_WIN'(N_WINDOW - 1));
   assign seed_end    = strobe && (state_q == ST_SEED) && (win_cnt_q == NB_WIN'(PRBS_LEN - 1));
   // Window total including the error of the strobe that closes the window.
   assign win_err_tot = 32'(win_err_q) + 32'(err_bit);
   assign lock_lost   = (state_q == ST_LOCK) && (state_d == ST_SEED);

   prbs_lfsr_load #(
      .PRBS_LEN (PRBS_LEN),
      .PRBS_TAP (PRBS_TAP)
   ) u_lfsr (
      .clk        (clk),
      .rst_n      (i_rst_n),
      .step_i     (strobe && (state_q != ST_IDLE)),
      .load_sel_i (state_q == ST_SEED),
      .load_bit_i (slicer),
      .fb_o       (fb),
      .state_o    (lfsr_state_unused)
   );

   always_comb begin
      phase_d = phase_q;
      if (beat) phase_d = (phase_q == NB_PHASE'(N_PHASES - 1)) ? '0 : phase_q + NB_PHASE'(1);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus_if.i_en) state_d = ST_SEED;
         ST_SEED:   if (seed_end) state_d = ST_VERIFY;
         ST_VERIFY: if (win_end) state_d = (win_err_tot <= 32'(LOCK_THR)) ? ST_LOCK : ST_SEED;
         ST_LOCK:   if (win_end && (win_err_tot > 32'(LOST_THR))) state_d = ST_SEED;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus_if.o_lock       = (state_q == ST_LOCK);
      bus_if.o_state      = state_q;
      bus_if.o_ber_samp   = samp_q;
      bus_if.o_ber_error  = berr_q;
      bus_if.o_ber_zero   = ber_zero_q;
      bus_if.o_resync_cnt = resync_q;
   end

   // SEED reuses the window counter to count seed strobes.
   always_comb begin
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
      if ((state_d != state_q) || win_end) begin
         win_cnt_d = '0;
         win_err_d = '0;
      end else if (strobe && (state_q != ST_IDLE)) begin
         win_cnt_d = win_cnt_q + NB_WIN'(1);
         win_err_d = win_err_q + NB_WIN'(err_bit && in_check);
      end
   end

   // BER counters keep their values across SEED/VERIFY after a loss of lock.
   always_comb begin
      samp_d     = samp_q;
      berr_d     = berr_q;
      resync_d   = resync_q;
      ber_zero_d = ber_zero_q;
      if (bus_if.i_en) begin
         ber_zero_d = (state_q == ST_LOCK) && (samp_q != '0) && (berr_q == '0);
         if (bus_if.i_clear) begin
            samp_d   = '0;
            berr_d   = '0;
            resync_d = '0;
         end else begin
            if (lock_strobe && (samp_q != '1)) samp_d = samp_q + NB_BER_CNT'(1);
            if (lock_strobe && err_bit && (berr_q != '1)) berr_d = berr_q + NB_BER_CNT'(1);
            if (lock_lost && (resync_q != 8'hFF)) resync_d = resync_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_q    <= '0;
         win_cnt_q  <= '0;
         win_err_q  <= '0;
         samp_q     <= '0;
         berr_q     <= '0;
         resync_q   <= '0;
         ber_zero_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         win_cnt_q  <= win_cnt_d;
         win_err_q  <= win_err_d;
         samp_q     <= samp_d;
         berr_q     <= berr_d;
         resync_q   <= resync_d;
         ber_zero_q <= ber_zero_d;
      end
   end

endmodule

// File: tb/tb_ber_sync_checker.sv
// Directed bench for ber_sync_checker: PRBS9 source, 4x oversampling, a
// 64-bit and a 4-bit counter instance fed the same stream.
module tb_ber_sync_checker;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ber_sync_checker_if #(.NB_INPUT(8), .N_PHASES(4), .NB_BER_CNT(64)) bus0 ();
   ber_sync_checker_if #(.NB_INPUT(8), .N_PHASES(4), .NB_BER_CNT(4))  bus1 ();

   assign bus1.i_en        = bus0.i_en;
   assign bus1.i_valid     = bus0.i_valid;
   assign bus1.i_data      = bus0.i_data;
   assign bus1.i_phase_sel = bus0.i_phase_sel;
   assign bus1.i_clear     = bus0.i_clear;

   ber_sync_checker #(.NB_INPUT(8), .N_PHASES(4), .NB_BER_CNT(64)) dut0 (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus_if  (bus0)
   );

   ber_sync_checker #(.NB_INPUT(8), .N_PHASES(4), .NB_BER_CNT(4)) dut1 (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus_if  (bus1)
   );

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q[$];
   string       tag_q[$];
   logic [8:0]  gen = 9'h1A5;

   // Reference PRBS9 source: x[n] = x[n-9] ^ x[n-5].
   task automatic gen_bit(output logic b);
      b   = gen[8] ^ gen[4];
      gen = {gen[7:0], b};
   endtask

   task automatic expect_v(input string t, input logic [63:0] e);
      tag_q.push_back(t);
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [63:0] obs);
      string       t;
      logic [63:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
      end
   endtask

   task automatic beat(input logic b, input logic clr);
      bus0.i_en    = 1'b1;
      bus0.i_valid = 1'b1;
      bus0.i_data  = {b, 7'($urandom)};
      bus0.i_clear = clr;
      @(negedge clk);
      bus0.i_valid = 1'b0;
      bus0.i_clear = 1'b0;
   endtask

   // One symbol = 4 beats; the test bit sits on phase 2, other phases carry
   // the true bit or (inv_other) its complement.
   task automatic sym(input logic flip, input logic inv_other);
      logic b;
      gen_bit(b);
      for (int p = 0; p < 4; p++) beat((p == 2) ? (b ^ flip) : (b ^ inv_other), 1'b0);
   endtask

   task automatic syms(input int n, input logic flip, input logic inv_other);
      for (int i = 0; i < n; i++) sym(flip, inv_other);
   endtask

   initial begin
      logic b;
      bus0.i_en        = 1'b0;
      bus0.i_valid     = 1'b0;
      bus0.i_data      = '0;
      bus0.i_phase_sel = 2'd2;
      bus0.i_clear     = 1'b0;
      rst_n            = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);

      expect_v("rst_state", 0);  check(64'(bus0.o_state));
      expect_v("rst_lock", 0);   check(64'(bus0.o_lock));
      expect_v("rst_samp", 0);   check(bus0.o_ber_samp);
      expect_v("rst_err", 0);    check(bus0.o_ber_error);
      expect_v("rst_zero", 0);   check(64'(bus0.o_ber_zero));
      expect_v("rst_resync", 0); check(64'(bus0.o_resync_cnt));

      rst_n = 1'b1;
      @(negedge clk);
      expect_v("idle_hold_en0", 0); check(64'(bus0.o_state));
      bus0.i_en = 1'b1;
      expect_v("idle_to_seed", 1);
      @(negedge clk);
      check(64'(bus0.o_state));

      // Acquisition: 9 seed strobes, then a 511-strobe verify window.
      expect_v("seed_after8", 1);   syms(8, 0, 0);   check(64'(bus0.o_state));
      expect_v("verify_after9", 2); syms(1, 0, 0);   check(64'(bus0.o_state));
      expect_v("nolock_519", 0);    syms(510, 0, 0); check(64'(bus0.o_lock));
      expect_v("lock_520", 1);
      expect_v("state_lock", 3);
      expect_v("samp_at_lock", 0);
      expect_v("zero_at_lock", 0);
      syms(1, 0, 0);
      check(64'(bus0.o_lock));
      check(64'(bus0.o_state));
      check(bus0.o_ber_samp);
      check(64'(bus0.o_ber_zero));

      // Counter visible right after the strobe; ber_zero one cycle later.
      gen_bit(b);
      expect_v("samp_latency", 1);
      expect_v("zero_lags", 0);
      beat(b, 0); beat(b, 0); beat(b, 0);
      check(bus0.o_ber_samp);
      check(64'(bus0.o_ber_zero));
      expect_v("zero_rises", 1);
      beat(b, 0);
      check(64'(bus0.o_ber_zero));

      expect_v("clean_samp", 1000);
      expect_v("clean_err", 0);
      expect_v("clean_zero", 1);
      expect_v("sat4_samp", 15);
      expect_v("sat4_err", 0);
      syms(999, 0, 0);
      check(bus0.o_ber_samp);
      check(bus0.o_ber_error);
      check(64'(bus0.o_ber_zero));
      check(64'(bus1.o_ber_samp));
      check(64'(bus1.o_ber_error));

      // One flipped bit per 100 strobes.
      expect_v("err_mid", 5);
      for (int i = 0; i < 500; i++) sym((i % 100) == 99, 0);
      check(bus0.o_ber_error);
      expect_v("err_end", 10);
      expect_v("err_samp", 2000);
      expect_v("err_lock", 1);
      expect_v("err_resync", 0);
      expect_v("err_zero", 0);
      expect_v("sat4_err10", 10);
      for (int i = 500; i < 1000; i++) sym((i % 100) == 99, 0);
      check(bus0.o_ber_error);
      check(bus0.o_ber_samp);
      check(64'(bus0.o_lock));
      check(64'(bus0.o_resync_cnt));
      check(64'(bus0.o_ber_zero));
      check(64'(bus1.o_ber_error));

      // Enable low: valid samples must be ignored entirely.
      expect_v("en0_samp", 2000);
      expect_v("en0_err", 10);
      expect_v("en0_state", 3);
      bus0.i_en = 1'b0;
      repeat (50) begin
         bus0.i_valid = 1'b1;
         bus0.i_data  = 8'($urandom);
         @(negedge clk);
      end
      bus0.i_valid = 1'b0;
      check(bus0.o_ber_samp);
      check(bus0.o_ber_error);
      check(64'(bus0.o_state));
      expect_v("en1_samp", 2100);
      expect_v("en1_err", 10);
      expect_v("en1_lock", 1);
      syms(100, 0, 0);
      check(bus0.o_ber_samp);
      check(bus0.o_ber_error);
      check(64'(bus0.o_lock));

      // Inverted stream: current LOCK window has 455 strobes left.
      expect_v("inv_still_lock", 1); syms(454, 1, 0); check(64'(bus0.o_lock));
      expect_v("loss_state", 1);
      expect_v("loss_resync", 1);
      expect_v("loss_samp", 2555);
      expect_v("loss_err", 465);
      expect_v("sat4_err15", 15);
      syms(1, 1, 0);
      check(64'(bus0.o_state));
      check(64'(bus0.o_resync_cnt));
      check(bus0.o_ber_samp);
      check(bus0.o_ber_error);
      check(64'(bus1.o_ber_error));
      expect_v("inv_nolock", 0);
      expect_v("inv_samp_hold", 2555);
      syms(567, 1, 0);
      check(64'(bus0.o_lock));
      check(bus0.o_ber_samp);

      // Restored stream: failing verify window, then reseed and relock.
      expect_v("relock_pre", 0); syms(992, 0, 0); check(64'(bus0.o_lock));
      expect_v("relock", 1);
      expect_v("relock_samp", 2555);
      expect_v("relock_resync", 1);
      syms(1, 0, 0);
      check(64'(bus0.o_lock));
      check(bus0.o_ber_samp);
      check(64'(bus0.o_resync_cnt));

      // Clear coincident with a LOCK strobe wins over the increment.
      gen_bit(b);
      expect_v("clr_samp", 0);
      expect_v("clr_err", 0);
      expect_v("clr_resync", 0);
      expect_v("clr_state", 3);
      expect_v("clr_sat4", 0);
      beat(b, 0); beat(b, 0); beat(b, 1);
      check(bus0.o_ber_samp);
      check(bus0.o_ber_error);
      check(64'(bus0.o_resync_cnt));
      check(64'(bus0.o_state));
      check(64'(bus1.o_ber_samp));
      beat(b, 0);
      expect_v("post_clr_samp", 1); syms(1, 0, 0); check(bus0.o_ber_samp);

      // Asynchronous reset pulse mid-LOCK.
      rst_n = 1'b0;
      #1;
      expect_v("mrst_state", 0);  check(64'(bus0.o_state));
      expect_v("mrst_lock", 0);   check(64'(bus0.o_lock));
      expect_v("mrst_samp", 0);   check(bus0.o_ber_samp);
      expect_v("mrst_err", 0);    check(bus0.o_ber_error);
      expect_v("mrst_zero", 0);   check(64'(bus0.o_ber_zero));
      expect_v("mrst_resync", 0); check(64'(bus0.o_resync_cnt));
      expect_v("mrst_sat4", 0);   check(64'(bus1.o_ber_samp));
      @(negedge clk);
      rst_n = 1'b1;
      expect_v("mrst_restart", 1);
      @(negedge clk);
      check(64'(bus0.o_state));

      // Wrong phase sees the complemented stream: verify fails every time.
      bus0.i_phase_sel = 2'd0;
      expect_v("wph_state1", 1);
      expect_v("wph_lock1", 0);
      syms(520, 0, 1);
      check(64'(bus0.o_state));
      check(64'(bus0.o_lock));
      expect_v("wph_state2", 1);
      expect_v("wph_lock2", 0);
      expect_v("wph_samp", 0);
      syms(520, 0, 1);
      check(64'(bus0.o_state));
      check(64'(bus0.o_lock));
      check(bus0.o_ber_samp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ber_sync_checker.md
BER_SYNC_CHECKER -- requirements
Module: ber_sync_checker

Interface
REQ-001 Parameter NB_INPUT, default 8: input sample width; MSB is the slicer bit.
REQ-002 Parameter N_PHASES, default 4: oversampling factor; NB_PHASE = max(1, $clog2(N_PHASES)).
REQ-003 Parameter PRBS_LEN, default 9, and PRBS_TAP, default 5: polynomial x^PRBS_LEN + x^PRBS_TAP + 1.
REQ-004 Parameter N_WINDOW, default 511: symbols per verify/monitor window.
REQ-005 Parameter LOCK_THR, default 0: maximum window errors for lock acquisition.
REQ-006 Parameter LOST_THR, default 64: window errors above this value declare loss of lock.
REQ-007 Parameter NB_BER_CNT, default 64: width of the BER counters.
REQ-008 Ports:
  - clk  in  1  clock; all state changes on the rising edge.
  - i_rst_n  in  1  reset; asynchronous, active-low.
  - i_en  in  1  enable; low freezes all state.
  - i_valid  in  1  sample qualifier.
  - i_data  in  NB_INPUT  input sample.
  - i_phase_sel  in  NB_PHASE  selected sampling phase.
  - i_clear  in  1  synchronous clear of BER counters and resync counter.
  - o_lock  out  1  high while in LOCK.
  - o_state  out  2  current state encoding.
  - o_ber_samp  out  NB_BER_CNT  symbols checked while locked.
  - o_ber_error  out  NB_BER_CNT  errors counted while locked.
  - o_ber_zero  out  1  registered: locked, o_ber_samp > 0 and o_ber_error == 0.
  - o_resync_cnt  out  8  number of lock losses, saturating.

Function
REQ-009 A beat is a cycle with i_en && i_valid. The phase counter increments modulo N_PHASES on each beat.
REQ-010 A strobe is a beat whose phase counter value equals i_phase_sel. The slicer bit is i_data[NB_INPUT-1].
REQ-011 The local LFSR is PRBS_LEN bits wide, Fibonacci form: fb = s[PRBS_LEN-1] ^ s[PRBS_TAP-1]; expected bit = fb. On a strobe, s <= {s[PRBS_LEN-2:0], ins}.
REQ-012 In LOCK and VERIFY, ins = fb. In SEED, ins = the slicer bit.
REQ-013 The error bit is the slicer bit XOR fb, evaluated on strobes in VERIFY and LOCK only.
REQ-014 State encoding: IDLE=0, SEED=1, VERIFY=2, LOCK=3.
REQ-015 IDLE -> SEED on the first cycle with i_en = 1.
REQ-016 SEED -> VERIFY after PRBS_LEN strobes.
REQ-017 VERIFY spans N_WINDOW strobes. At window end: errors <= LOCK_THR -> LOCK; otherwise -> SEED.
REQ-018 LOCK runs consecutive N_WINDOW-strobe windows. At the end of a window with errors > LOST_THR -> SEED and o_resync_cnt increments (saturating at 255).
REQ-019 The window strobe and error counters clear on every window end and on every state entry.
REQ-020 o_ber_samp increments on each LOCK strobe. o_ber_error adds the error bit on each LOCK strobe. Both saturate at 2^NB_BER_CNT-1 and hold through SEED/VERIFY after a loss of lock.
REQ-021 Counter latency: a strobe in cycle t is visible on the counter outputs in cycle t+1. o_ber_zero lags the counters by one further cycle.
REQ-022 i_clear zeroes o_ber_samp, o_ber_error and o_resync_cnt next cycle. It has priority over a simultaneous increment and does not change state.
REQ-023 i_en = 0 holds every register, including the phase counter and LFSR. i_valid = 0 with i_en = 1 holds everything except the IDLE->SEED transition.
REQ-024 A change of i_phase_sel takes effect on the next beat. No automatic resync occurs; resync follows only via LOST_THR.

Reset
REQ-025 On i_rst_n = 0, asynchronously:
  - state = IDLE; LFSR = all ones; phase counter and window counters = 0.
  - o_ber_samp = 0, o_ber_error = 0, o_resync_cnt = 0.
  - o_lock = 0, o_ber_zero = 0, o_state = 0.
REQ-026 Reset deassertion mid-operation restarts from IDLE. No counter value is retained.

Structure
REQ-027 A shared package holds the state encoding constants, the PRBS polynomial defaults (9/5, 7/6, 15/14) and the NB_PHASE width function.
REQ-028 The LFSR is a sub-module prbs_lfsr_load with parameters PRBS_LEN and PRBS_TAP, ports for step, load-select and load bit, and outputs fb and state. It is reusable as a generator.

Verification
REQ-029 Clean PRBS9 at N_PHASES = 4, i_phase_sel = 2, no errors:
  - o_lock rises 9 + 511 strobes after the first strobe.
  - After a further 1000 strobes: o_ber_samp = 1000, o_ber_error = 0, o_ber_zero = 1.
REQ-030 Locked, then one flipped bit every 100 strobes:
  - o_ber_error rises by 1 per 100 strobes.
  - Lock holds; o_resync_cnt = 0.
REQ-031 Locked, then the stream inverted for 2 windows:
  - Window errors > 64 -> state SEED; o_resync_cnt = 1.
  - Relock after restoring the stream; o_ber_samp retained.
REQ-032 Wrong i_phase_sel on 8-sample runs of equal value at phase boundaries:
  - VERIFY fails -> state returns to SEED repeatedly; o_lock stays 0.
REQ-033 i_en low for 50 cycles mid-LOCK, then high: all counters and the LFSR are unchanged; no spurious error counts.
REQ-034 i_clear asserted together with a strobe: counters read 0 next cycle. Also cover NB_BER_CNT = 4 saturation at 15 and i_rst_n pulsed mid-LOCK giving all-zero outputs.
